vga_line_fetch_sched: RTL and testbench



---
 rtl/vga_fb_pkg.sv | 10 +
 rtl/vga_line_fetch_sched_if.sv | 12 +
 rtl/vga_fetch_addr_gen.sv | 57 +++++
 rtl/vga_line_fetch_sched.sv | 108 ++++++++++
 tb/tb_vga_line_fetch_sched.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared FSM state type and default geometry for the VGA line-fetch scheduler.
package vga_fb_pkg;
    typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_CMD} state_t;
    localparam int DEF_H_ACT       = 640;
    localparam int DEF_V_ACT       = 480;
    localparam int DEF_BURST_LEN   = 8;
    localparam int DEF_WR_SLOT     = 4;
    localparam int FB_ADDR_W       = 22;
    localparam int BURSTS_PER_LINE = DEF_H_ACT / DEF_BURST_LEN;
endpackage

// File: rtl/vga_line_fetch_sched_if.sv
// vga_line_fetch_sched_if: frame-buffer memory command port shared by display reads and the writer.
interface vga_line_fetch_sched_if #(
    parameter int ADDR_W = vga_fb_pkg::FB_ADDR_W
);
    logic              oMem_Req;
    logic              oMem_We;
    logic [ADDR_W-1:0] oMem_Addr;
    logic              iMem_Ack;
    logic              iMem_Rvalid;
    modport master (output oMem_Req, oMem_We, oMem_Addr, input iMem_Ack, iMem_Rvalid);
    modport slave  (input oMem_Req, oMem_We, oMem_Addr, output iMem_Ack, iMem_Rvalid);
endinterface

// File: rtl/vga_fetch_addr_gen.sv
// vga_fetch_addr_gen: line base, burst and pixel counters; yields the read address and line-done.
module vga_fetch_addr_gen #(
    parameter int H_ACT     = vga_fb_pkg::DEF_H_ACT,
    parameter int V_ACT     = vga_fb_pkg::DEF_V_ACT,
    parameter int BURST_LEN = vga_fb_pkg::DEF_BURST_LEN,
    parameter int ADDR_W    = vga_fb_pkg::FB_ADDR_W
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              i_start,
    input  logic [10:0]       i_y,
    input  logic              i_busy,
    input  logic              i_beat,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [9:0]        o_pix,
    output logic              o_burst_end,
    output logic              o_line_done
);
    localparam int BPL = H_ACT / BURST_LEN;
    localparam int BW  = $clog2(BPL + 1);
    localparam int CW  = $clog2(BURST_LEN + 1);
    logic [ADDR_W-1:0] r_base;
    logic [BW-1:0]     r_burst;
    logic [9:0]        r_pix;
    logic [CW-1:0]     r_beat;
    logic              r_restart;
    logic [10:0]       w_y;
    logic              w_clear;
    assign w_y         = (i_y >= 11'(V_ACT)) ? 11'(V_ACT - 1) : i_y;
    assign o_rd_addr   = r_base + ADDR_W'(int'(r_burst) * BURST_LEN);
    assign o_pix       = r_pix;
    assign o_burst_end = i_beat && (r_beat == CW'(BURST_LEN - 1));
    assign o_line_done = o_burst_end && !r_restart && !i_start && (r_burst == BW'(BPL - 1));
    // A new line that lands mid-burst only takes effect once that burst has drained.
    assign w_clear     = (i_start && !i_busy) || (o_burst_end && (r_restart || i_start || o_line_done));
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_base    <= '0;
            r_burst   <= '0;
            r_pix     <= '0;
            r_beat    <= '0;
            r_restart <= 1'b0;
        end else begin
            if (i_start) r_base <= ADDR_W'(int'(w_y) * H_ACT);
            if (i_beat) begin
                r_pix  <= r_pix + 10'd1;
                r_beat <= o_burst_end ? '0 : r_beat + CW'(1);
                if (o_burst_end) r_burst <= r_burst + BW'(1);
            end
            if (w_clear) begin
                r_burst <= '0;
                r_pix   <= '0;
            end
            r_restart <= (i_start && i_busy && !o_burst_end) || (r_restart && !o_burst_end);
        end
    end
endmodule

// File: rtl/vga_line_fetch_sched.sv
// vga_line_fetch_sched: prefetches display lines into a ping-pong buffer and shares the
// frame-buffer command port with the writer. Define WR_FAIR_EN to bound writer starvation.
module vga_line_fetch_sched
    import vga_fb_pkg::*;
#(
`ifdef WR_FAIR_EN
    parameter int WR_SLOT   = DEF_WR_SLOT,
`endif
    parameter int H_ACT     = DEF_H_ACT,
    parameter int V_ACT     = DEF_V_ACT,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int ADDR_W    = FB_ADDR_W
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic                   iLine_Start,
    input  logic [10:0]            iLine_Y,
    vga_line_fetch_sched_if.master mem,
    input  logic                   iWr_Req,
    input  logic [ADDR_W-1:0]      iWr_Addr,
    output logic                   oWr_Ack,
    output logic                   oBuf_We,
    output logic [9:0]             oBuf_Addr,
    output logic                   oBuf_Bank,
    output logic                   oLine_Ready,
    output logic                   oUnderrun
);
    state_t            r_state, w_next;
    logic              r_pending, r_mem_req, r_mem_we, r_wr_ack, r_buf_we, r_bank;
    logic              r_done_d, r_line_ready, r_underrun;
    logic [ADDR_W-1:0] r_mem_addr, w_rd_addr;
    logic [9:0]        r_buf_addr, w_pix;
    logic              w_busy, w_beat, w_burst_end, w_line_done, w_wr, w_force_wr;
    assign w_busy = (r_state == RD_CMD) || (r_state == RD_DATA);
    assign w_beat = (r_state == RD_DATA) && mem.iMem_Rvalid;
    // The writer still holds its request during the ack cycle; don't grant it twice.
    assign w_wr   = iWr_Req && !r_wr_ack;
`ifdef WR_FAIR_EN
    localparam int FW = $clog2(WR_SLOT + 1);
    logic [FW-1:0] r_fair;
    assign w_force_wr = w_wr && (r_fair == FW'(WR_SLOT));
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            r_fair <= '0;
        else if (!iWr_Req || (r_state == IDLE && w_next == WR_CMD))
            r_fair <= '0;
        else if (r_state == RD_CMD && mem.iMem_Ack && r_fair != FW'(WR_SLOT))
            r_fair <= r_fair + FW'(1);
    end
`else
    assign w_force_wr = 1'b0;
`endif
    vga_fetch_addr_gen #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)
    ) u_addr (
        .iCLK, .iRST_N, .i_start(iLine_Start), .i_y(iLine_Y), .i_busy(w_busy), .i_beat(w_beat),
        .o_rd_addr(w_rd_addr), .o_pix(w_pix), .o_burst_end(w_burst_end), .o_line_done(w_line_done)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_force_wr ? WR_CMD : r_pending ? RD_CMD : w_wr ? WR_CMD : IDLE;
            RD_CMD:  w_next = mem.iMem_Ack ? RD_DATA : RD_CMD;
            RD_DATA: w_next = w_burst_end ? IDLE : RD_DATA;
            WR_CMD:  w_next = mem.iMem_Ack ? IDLE : WR_CMD;
            default: w_next = IDLE;
        endcase
    end
    // Bank swap trails the last beat by a cycle so that beat still lands in the filling bank.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state      <= IDLE;
            r_pending    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_wr_ack     <= 1'b0;
            r_buf_we     <= 1'b0;
            r_buf_addr   <= '0;
            r_bank       <= 1'b0;
            r_done_d     <= 1'b0;
            r_line_ready <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_mem_req    <= (w_next == RD_CMD) || (w_next == WR_CMD);
            r_mem_we     <= (w_next == WR_CMD);
            if (r_state == IDLE) r_mem_addr <= (w_next == WR_CMD) ? iWr_Addr : w_rd_addr;
            r_wr_ack     <= (r_state == WR_CMD) && mem.iMem_Ack;
            r_buf_we     <= w_beat;
            r_buf_addr   <= r_done_d ? '0 : w_beat ? w_pix : r_buf_addr;
            r_done_d     <= w_line_done;
            r_line_ready <= r_done_d;
            r_bank       <= r_bank ^ r_done_d;
            r_pending    <= iLine_Start || (r_pending && !w_line_done);
            r_underrun   <= r_underrun || (iLine_Start && r_pending);
        end
    end
    assign mem.oMem_Req  = r_mem_req;
    assign mem.oMem_We   = r_mem_we;
    assign mem.oMem_Addr = r_mem_addr;
    assign oWr_Ack       = r_wr_ack;
    assign oBuf_We       = r_buf_we;
    assign oBuf_Addr     = r_buf_addr;
    assign oBuf_Bank     = r_bank;
    assign oLine_Ready   = r_line_ready;
    assign oUnderrun     = r_underrun;
endmodule

// File: tb/tb_vga_line_fetch_sched.sv
// tb_vga_line_fetch_sched: scoreboard bench; expected memory commands are queued at stimulus
// time and a negedge monitor pops and compares every accepted command.
module tb_vga_line_fetch_sched;
    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iLine_Start = 1'b0;
    logic [10:0] iLine_Y = '0;
    logic        iWr_Req = 1'b0;
    logic [21:0] iWr_Addr = '0;
    logic        oWr_Ack, oBuf_We, oBuf_Bank, oLine_Ready, oUnderrun;
    logic [9:0]  oBuf_Addr;
    int checks = 0, errors = 0;
    int cmd_cnt = 0, buf_cnt = 0, lr_cnt = 0, wack_cnt = 0;
    int last_pix = 0;
    logic exp_bank = 1'b0;
    logic [22:0] q_cmd[$];
    logic [22:0] exp_cmd;

    vga_line_fetch_sched_if #(.ADDR_W(22)) bus();

    vga_line_fetch_sched dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iLine_Start(iLine_Start), .iLine_Y(iLine_Y), .mem(bus),
        .iWr_Req(iWr_Req), .iWr_Addr(iWr_Addr), .oWr_Ack(oWr_Ack), .oBuf_We(oBuf_We),
        .oBuf_Addr(oBuf_Addr), .oBuf_Bank(oBuf_Bank), .oLine_Ready(oLine_Ready), .oUnderrun(oUnderrun)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    task automatic push_reads(input int base, input int from, input int to);
        for (int i = from; i < to; i++) q_cmd.push_back({1'b0, 22'(base + i * 8)});
    endtask

    task automatic start_line(input int y);
        @(posedge iCLK); #1;
        iLine_Start = 1'b1;
        iLine_Y = 11'(y);
        @(posedge iCLK); #1;
        iLine_Start = 1'b0;
    endtask

    task automatic step();
        @(negedge iCLK); #1;
    endtask

    task automatic wait_lines(input int n, input string nm);
        int k = 0;
        while (lr_cnt < n && k < 2000) begin step(); k++; end
        checks++;
        if (lr_cnt < n) begin
            errors++;
            $display("FAIL %s: timeout, line_ready count %0d required %0d", nm, lr_cnt, n);
        end
        exp_bank = ~exp_bank;
    endtask

    task automatic wait_cmds(input int n, input string nm);
        int k = 0;
        while (cmd_cnt < n && k < 200) begin step(); k++; end
        chk(nm, cmd_cnt, n);
    endtask

    task automatic wait_wack(input string nm);
        int k = 0;
        while (!oWr_Ack && k < 2000) begin step(); k++; end
        chk(nm, oWr_Ack, 1);
    endtask

    always @(negedge iCLK) begin
        if (iRST_N) begin
            if (bus.oMem_Req && bus.iMem_Ack) begin
                cmd_cnt++;
                if (q_cmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_extra: got we=%0b addr=0x%0h, required no command", bus.oMem_We, bus.oMem_Addr);
                end else begin
                    exp_cmd = q_cmd.pop_front();
                    chk("cmd_we_addr", {9'd0, bus.oMem_We, bus.oMem_Addr}, {9'd0, exp_cmd});
                end
            end
            if (oBuf_We) begin
                buf_cnt++;
                last_pix = int'(oBuf_Addr);
                chk("buf_bank", oBuf_Bank, exp_bank);
            end
            if (oLine_Ready) lr_cnt++;
            if (oWr_Ack) wack_cnt++;
        end
    end

    initial begin
        int c0, b0, l0, w0;
        bus.iMem_Ack = 1'b1;
        bus.iMem_Rvalid = 1'b1;
        #1;
        chk("rst_req", bus.oMem_Req, 0);
        chk("rst_we", bus.oMem_We, 0);
        chk("rst_addr", bus.oMem_Addr, 0);
        chk("rst_wack", oWr_Ack, 0);
        chk("rst_bufwe", oBuf_We, 0);
        chk("rst_bufaddr", oBuf_Addr, 0);
        chk("rst_bank", oBuf_Bank, 0);
        chk("rst_ready", oLine_Ready, 0);
        chk("rst_underrun", oUnderrun, 0);
        repeat (3) @(posedge iCLK);
        #1 iRST_N = 1'b1;

        // Line fetch Y=2: 1280..1912, 640 beats, one ready, bank 0 -> 1
        c0 = cmd_cnt; b0 = buf_cnt; l0 = lr_cnt;
        push_reads(1280, 0, 80);
        start_line(2);
        wait_lines(l0 + 1, "t1_timeout");
        chk("t1_cmds", cmd_cnt - c0, 80);
        chk("t1_beats", buf_cnt - b0, 640);
        chk("t1_last_pix", last_pix, 639);
        chk("t1_bank", oBuf_Bank, 1);
        repeat (3) step();
        chk("t1_ready_pulse", lr_cnt - l0, 1);
        chk("t1_bufaddr_clr", oBuf_Addr, 0);

        // Arbitration: write waits for the whole line Y=0
        c0 = cmd_cnt; l0 = lr_cnt; w0 = wack_cnt;
        push_reads(0, 0, 80);
        q_cmd.push_back({1'b1, 22'h3FFFF0});
        start_line(0);
        iWr_Req = 1'b1;
        iWr_Addr = 22'h3FFFF0;
        wait_wack("t2_wack_timeout");
        chk("t2_line_before_write", lr_cnt - l0, 1);
        @(posedge iCLK); #1;
        iWr_Req = 1'b0;
        repeat (5) step();
        exp_bank = ~exp_bank;
        chk("t2_wack_once", wack_cnt - w0, 1);
        chk("t2_cmds", cmd_cnt - c0, 81);
        chk("t2_bank", oBuf_Bank, 0);

        // Ack stall on the first command of line Y=1
        c0 = cmd_cnt; l0 = lr_cnt;
        bus.iMem_Ack = 1'b0;
        push_reads(640, 0, 80);
        start_line(1);
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_hold_req", bus.oMem_Req, 1);
            chk("t3_hold_addr", bus.oMem_Addr, 640);
        end
        @(posedge iCLK); #1;
        bus.iMem_Ack = 1'b1;
        step();
        chk("t3_one_accept", cmd_cnt - c0, 1);
        @(posedge iCLK); #1;
        chk("t3_left_cmd", bus.oMem_Req, 0);
        wait_lines(l0 + 1, "t3_timeout");
        chk("t3_bank", oBuf_Bank, 1);

        // Underrun: Y=5 aborted after three bursts, Y=6 restarts at 3840
        c0 = cmd_cnt; b0 = buf_cnt; l0 = lr_cnt;
        push_reads(3200, 0, 3);
        push_reads(3840, 0, 80);
        start_line(5);
        wait_cmds(c0 + 3, "t4_three_bursts");
        @(posedge iCLK); #1;
        iLine_Start = 1'b1;
        iLine_Y = 11'd6;
        @(posedge iCLK); #1;
        iLine_Start = 1'b0;
        chk("t4_underrun", oUnderrun, 1);
        chk("t4_no_ready_yet", lr_cnt - l0, 0);
        wait_lines(l0 + 1, "t4_timeout");
        chk("t4_beats", buf_cnt - b0, 664);
        chk("t4_cmds", cmd_cnt - c0, 83);
        chk("t4_bank", oBuf_Bank, 0);
        chk("t4_underrun_sticky", oUnderrun, 1);

        // Y beyond the frame clamps to the last line (479*640)
        l0 = lr_cnt;
        push_reads(306560, 0, 80);
        start_line(600);
        wait_lines(l0 + 1, "t7_timeout");
        chk("t7_bank", oBuf_Bank, 1);

        // Reset after four beats of a burst
        c0 = cmd_cnt;
        q_cmd.push_back({1'b0, 22'd1920});
        start_line(3);
        wait_cmds(c0 + 1, "t5_first_cmd");
        b0 = buf_cnt;
        begin
            int k = 0;
            while (buf_cnt < b0 + 4 && k < 50) begin step(); k++; end
        end
        iRST_N = 1'b0;
        #1;
        chk("t5_req", bus.oMem_Req, 0);
        chk("t5_bufwe", oBuf_We, 0);
        chk("t5_bufaddr", oBuf_Addr, 0);
        chk("t5_bank", oBuf_Bank, 0);
        chk("t5_underrun", oUnderrun, 0);
        chk("t5_addr", bus.oMem_Addr, 0);
        exp_bank = 1'b0;
        repeat (2) @(posedge iCLK);
        #1 iRST_N = 1'b1;
        c0 = cmd_cnt; b0 = buf_cnt;
        repeat (20) step();
        chk("t5_no_beats", buf_cnt - b0, 0);
        chk("t5_no_cmds", cmd_cnt - c0, 0);

`ifdef WR_FAIR_EN
        // Fairness: write slips in after four read bursts, reads resume at burst 4
        c0 = cmd_cnt; l0 = lr_cnt;
        push_reads(4480, 0, 4);
        q_cmd.push_back({1'b1, 22'h00ABCD});
        push_reads(4480, 4, 80);
        start_line(7);
        iWr_Req = 1'b1;
        iWr_Addr = 22'h00ABCD;
        wait_wack("t6_wack_timeout");
        chk("t6_reads_before_write", cmd_cnt - c0, 5);
        @(posedge iCLK); #1;
        iWr_Req = 1'b0;
        wait_lines(l0 + 1, "t6_timeout");
        chk("t6_cmds", cmd_cnt - c0, 81);
`endif

        repeat (5) step();
        chk("queue_drained", q_cmd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
